// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        PRIO_D = 1'b0,
        PRIO_I = 1'b1
    } prio_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } resp_owner_t;

    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive cycles in which a fetch request waits without a grant and
// flags when that wait reaches the limit, so the fetch port wins next cycle.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req,
    input  logic                    i_gnt,
    output logic                    force_i,
    output logic [STARVE_CNT_W-1:0] cnt
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (reset || !i_req || i_gnt) begin
            cnt_d = '0;
        end else if (cnt_q < LIMIT) begin
            cnt_d = cnt_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Compare the next count so the priority flip lands on the very next cycle.
    assign force_i = (cnt_d == LIMIT);
    assign cnt     = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read, byte-write memory between the fetch (I) and
// load/store (D) ports; D has priority, bounded by a starvation counter for I.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADD_WIDTH    = 17,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req,
    input  logic [31:0]             i_add,
    output logic                    i_gnt,
    output logic                    i_rvalid,
    output logic [31:0]             i_rdata,
    input  logic                    d_req,
    input  logic [31:0]             d_add,
    input  logic [3:0]              d_wen,
    input  logic [31:0]             d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [31:0]             d_rdata,
    output logic [31:0]             m_add,
    output logic [3:0]              m_wen,
    output logic [31:0]             m_wdata,
    input  logic [31:0]             m_rdata,
    output prio_state_t             dbg_state,
    output logic [STARVE_CNT_W-1:0] dbg_starve_cnt
);

    if (ADD_WIDTH < 2 || ADD_WIDTH > 32 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_params
        $error("mem_port_arbiter: parameter out of range");
    end

    prio_state_t             state_q, state_d;
    resp_owner_t             resp_sel_q, resp_sel_d;
    logic [31:0]             m_add_q, m_add_d;
    logic                    force_i;
    logic [STARVE_CNT_W-1:0] starve_cnt;

    // Handshake: a requester raises *_req with its command and holds it
    // unchanged until it sees *_gnt high in the same cycle; that cycle the
    // access is issued, and *_rvalid pulses exactly one cycle later. A grant
    // cut off by reset yields no rvalid and the request must be reissued.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (state_q == PRIO_I) begin
                i_gnt = i_req;
                d_gnt = d_req && !i_req;
            end else begin
                d_gnt = d_req;
                i_gnt = i_req && !d_req;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PRIO_D:  if (force_i) state_d = PRIO_I;
            PRIO_I:  if (i_gnt || !i_req) state_d = PRIO_D;
            default: state_d = PRIO_D;
        endcase
        if (reset) begin
            state_d = PRIO_D;
        end
    end

    mem_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_gnt   (i_gnt),
        .force_i (force_i),
        .cnt     (starve_cnt)
    );

    // Idle cycles keep the last address on the bus so the memory sees no toggling.
    always_comb begin
        m_add_d    = m_add_q;
        m_wen      = 4'b0000;
        m_wdata    = '0;
        resp_sel_d = OWN_NONE;
        if (reset) begin
            m_add_d = '0;
        end else if (i_gnt) begin
            m_add_d    = i_add;
            resp_sel_d = OWN_I;
        end else if (d_gnt) begin
            m_add_d    = d_add;
            m_wen      = d_wen;
            m_wdata    = d_wdata;
            resp_sel_d = OWN_D;
        end
    end

    assign m_add = m_add_d;

    always_comb begin
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        if (!reset) begin
            case (resp_sel_q)
                OWN_I: begin
                    i_rvalid = 1'b1;
                    i_rdata  = m_rdata;
                end
                OWN_D: begin
                    d_rvalid = 1'b1;
                    d_rdata  = m_rdata;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PRIO_D;
            resp_sel_q <= OWN_NONE;
            m_add_q    <= '0;
        end else begin
            state_q    <= state_d;
            resp_sel_q <= resp_sel_d;
            m_add_q    <= m_add_d;
        end
    end

    assign dbg_state      = state_q;
    assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus
// random traffic checked every cycle against a behavioural arbitration model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int LIM   = 4;
    localparam int WORDS = 32768;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_add;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [31:0] d_add;
    logic [3:0]  d_wen;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] m_add;
    logic [3:0]  m_wen;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    prio_state_t dbg_state;
    logic [3:0]  dbg_starve_cnt;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .ADD_WIDTH(17),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_req          (i_req),
        .i_add          (i_add),
        .i_gnt          (i_gnt),
        .i_rvalid       (i_rvalid),
        .i_rdata        (i_rdata),
        .d_req          (d_req),
        .d_add          (d_add),
        .d_wen          (d_wen),
        .d_wdata        (d_wdata),
        .d_gnt          (d_gnt),
        .d_rvalid       (d_rvalid),
        .d_rdata        (d_rdata),
        .m_add          (m_add),
        .m_wen          (m_wen),
        .m_wdata        (m_wdata),
        .m_rdata        (m_rdata),
        .dbg_state      (dbg_state),
        .dbg_starve_cnt (dbg_starve_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int k);
        return (32'(k) * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    // Memory device: registered read of the pre-write word, byte-enabled write.
    logic [31:0] mem [0:WORDS-1];
    initial begin
        for (int k = 0; k < WORDS; k++) mem[k] <= init_word(k);
        m_rdata <= 32'h0;
    end
    always @(posedge clk) begin
        m_rdata <= mem[m_add[16:2]];
        for (int b = 0; b < 4; b++) begin
            if (m_wen[b]) mem[m_add[16:2]][8*b +: 8] <= m_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: who is owed a response, and the arbitration rules.
    logic [31:0] model_mem [0:WORDS-1];
    logic [31:0] exp_q[$];
    int          own_q[$];
    bit          m_prio_i = 1'b0;
    int          m_cnt    = 0;
    logic [31:0] m_hold   = 32'h0;
    bit          last_eg_i = 1'b0;
    bit          last_eg_d = 1'b0;

    initial begin
        for (int k = 0; k < WORDS; k++) model_mem[k] = init_word(k);
    end

    bit          e_gi, e_gd;
    int          e_own;
    logic [31:0] e_data, e_add;
    int          e_idx;

    always @(negedge clk) begin
        if (reset) begin
            e_gi = 1'b0;
            e_gd = 1'b0;
        end else if (m_prio_i) begin
            e_gi = i_req;
            e_gd = d_req && !i_req;
        end else begin
            e_gd = d_req;
            e_gi = i_req && !d_req;
        end
        e_add = reset ? 32'h0 : (e_gi ? i_add : (e_gd ? d_add : m_hold));

        e_own  = 0;
        e_data = 32'h0;
        if (own_q.size() > 0) begin
            e_own  = own_q.pop_front();
            e_data = exp_q.pop_front();
        end
        if (reset) e_own = 0;

        chk("mdl_i_gnt", 32'(i_gnt), 32'(e_gi));
        chk("mdl_d_gnt", 32'(d_gnt), 32'(e_gd));
        chk("mdl_m_add", m_add, e_add);
        chk("mdl_m_wen", 32'(m_wen), e_gd ? 32'(d_wen) : 32'h0);
        chk("mdl_m_wdata", m_wdata, e_gd ? d_wdata : 32'h0);
        chk("mdl_i_rvalid", 32'(i_rvalid), 32'(e_own == 1));
        chk("mdl_d_rvalid", 32'(d_rvalid), 32'(e_own == 2));
        chk("mdl_i_rdata", i_rdata, (e_own == 1) ? e_data : 32'h0);
        chk("mdl_d_rdata", d_rdata, (e_own == 2) ? e_data : 32'h0);
        if (!reset) begin
            chk("mdl_state", 32'(dbg_state), m_prio_i ? 32'(PRIO_I) : 32'(PRIO_D));
            chk("mdl_starve_cnt", 32'(dbg_starve_cnt), 32'(m_cnt));
        end

        if (reset) begin
            own_q.push_back(0);
            exp_q.push_back(32'h0);
            m_prio_i = 1'b0;
            m_cnt    = 0;
            m_hold   = 32'h0;
        end else begin
            if (e_gi) begin
                own_q.push_back(1);
                exp_q.push_back(model_mem[i_add[16:2]]);
            end else if (e_gd) begin
                e_idx = int'(d_add[16:2]);
                own_q.push_back(2);
                exp_q.push_back(model_mem[e_idx]);
                for (int b = 0; b < 4; b++) begin
                    if (d_wen[b]) model_mem[e_idx][8*b +: 8] = d_wdata[8*b +: 8];
                end
            end else begin
                own_q.push_back(0);
                exp_q.push_back(32'h0);
            end
            m_hold = e_add;
            if (i_req && !e_gi) m_cnt = (m_cnt + 1 > LIM) ? LIM : m_cnt + 1;
            else m_cnt = 0;
            if (m_prio_i) m_prio_i = !(e_gi || !i_req);
            else m_prio_i = (m_cnt == LIM);
        end
        last_eg_i = e_gi;
        last_eg_d = e_gd;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_idle();
        i_req = 1'b0; i_add = 32'h0;
        d_req = 1'b0; d_add = 32'h0; d_wen = 4'h0; d_wdata = 32'h0;
    endtask

    task automatic drive_d(input logic [31:0] a, input logic [3:0] w, input logic [31:0] wd);
        d_req = 1'b1; d_add = a; d_wen = w; d_wdata = wd;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[16:2] = 15'($urandom_range(0, 31));
        return a;
    endfunction

    initial begin
        reset = 1'b1;
        drive_idle();
        repeat (3) step();
        reset = 1'b0;
        probe();
        chk("rst_state", 32'(dbg_state), 32'(PRIO_D));
        chk("rst_cnt", 32'(dbg_starve_cnt), 32'h0);
        chk("rst_m_add", m_add, 32'h0);
        chk("rst_rvalid", 32'({i_rvalid, d_rvalid}), 32'h0);

        // Full-word store, then single fetch of the same word next cycle.
        step(); drive_d(32'h10, 4'hF, 32'hDEADBEEF);
        probe(); chk("st_gnt", 32'(d_gnt), 32'h1);
        step(); drive_idle(); i_req = 1'b1; i_add = 32'h10;
        probe(); chk("fetch_gnt", 32'(i_gnt), 32'h1);
        chk("st_ack", 32'(d_rvalid), 32'h1);
        step(); drive_idle();
        probe(); chk("fetch_rvalid", 32'(i_rvalid), 32'h1);
        chk("fetch_rdata", i_rdata, 32'hDEADBEEF);
        chk("fetch_no_d", 32'(d_rvalid), 32'h0);

        // Byte store over 0x11223344, then load of the same word.
        step(); drive_d(32'h20, 4'hF, 32'h11223344);
        step(); drive_d(32'h20, 4'b0010, 32'h0000AB00);
        probe(); chk("bst_wen", 32'(m_wen), 32'h2);
        step(); drive_d(32'h20, 4'h0, 32'h0);
        probe(); chk("bst_ack", 32'(d_rvalid), 32'h1);
        chk("bst_old", d_rdata, 32'h11223344);
        step(); drive_idle();
        probe(); chk("bld_data", d_rdata, 32'h1122AB44);

        // Contention: D wins four cycles, then I once, then D again.
        step(); i_req = 1'b1; i_add = 32'h40; drive_d(32'h44, 4'h0, 32'h0);
        for (int c = 0; c < 6; c++) begin
            probe();
            chk("cont_d_gnt", 32'(d_gnt), 32'(c != 4));
            chk("cont_i_gnt", 32'(i_gnt), 32'(c == 4));
            step();
        end
        drive_idle();
        repeat (2) step();

        // Pipelined I, D, I with routing checks.
        i_req = 1'b1; i_add = 32'h10;
        probe(); chk("pipe_g0", 32'(i_gnt), 32'h1);
        step(); drive_idle(); drive_d(32'h20, 4'h0, 32'h0);
        probe(); chk("pipe_g1", 32'(d_gnt), 32'h1);
        chk("pipe_r0", i_rdata, 32'hDEADBEEF);
        chk("pipe_x0", 32'(d_rvalid), 32'h0);
        step(); drive_idle(); i_req = 1'b1; i_add = 32'h40;
        probe(); chk("pipe_g2", 32'(i_gnt), 32'h1);
        chk("pipe_r1", d_rdata, 32'h1122AB44);
        chk("pipe_x1", 32'({i_rvalid, i_rdata}), 32'h0);
        step(); drive_idle();
        probe(); chk("pipe_r2", i_rdata, 32'h4A4A1010);
        chk("pipe_x2", 32'(d_rvalid), 32'h0);

        // Reset right after a granted store; the response must be dropped.
        step(); drive_d(32'h80, 4'hF, 32'hCAFEF00D); i_req = 1'b1; i_add = 32'h40;
        probe(); chk("rmid_gnt", 32'(d_gnt), 32'h1);
        step(); reset = 1'b1; drive_d(32'h84, 4'hF, 32'h12345678);
        probe(); chk("rmid_rvalid", 32'(d_rvalid), 32'h0);
        chk("rmid_wen", 32'(m_wen), 32'h0);
        chk("rmid_gnts", 32'({i_gnt, d_gnt}), 32'h0);
        step(); reset = 1'b0; drive_idle();
        probe(); chk("rmid_state", 32'(dbg_state), 32'(PRIO_D));
        chk("rmid_cnt", 32'(dbg_starve_cnt), 32'h0);
        chk("rmid_no_rv", 32'(d_rvalid), 32'h0);
        step(); drive_d(32'h80, 4'h0, 32'h0);
        step(); drive_idle();
        probe(); chk("rmid_commit", d_rdata, 32'hCAFEF00D);

        // Idle stretch.
        for (int c = 0; c < 10; c++) begin
            step();
            probe();
            chk("idle_gnt", 32'({i_gnt, d_gnt}), 32'h0);
            chk("idle_wen", 32'(m_wen), 32'h0);
            chk("idle_rv", 32'({i_rvalid, d_rvalid}), 32'h0);
            chk("idle_cnt", 32'(dbg_starve_cnt), 32'h0);
        end

        // Random traffic honouring the hold-until-grant rule, with rare resets.
        for (int n = 0; n < 4000; n++) begin
            step();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 199) == 0) reset = 1'b1;
            if (!i_req || last_eg_i) begin
                i_req = ($urandom_range(0, 99) < 55);
                i_add = rand_addr();
            end
            if (!d_req || last_eg_d) begin
                d_req   = ($urandom_range(0, 99) < 80);
                d_add   = rand_addr();
                d_wen   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                d_wdata = $urandom;
            end
        end
        step(); reset = 1'b0; drive_idle();
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port, synchronous-read, byte-write memory between the core's instruction-fetch port (I, read-only) and its load/store port (D, read/write). It sits between the fetch/LSU stages and the memory, issuing at most one memory access per cycle and routing the one-cycle-latency read data back to the winner. D has fixed priority, bounded by an anti-starvation counter that guarantees I forward progress.

## Interface
- ADD_WIDTH, 17, byte-address bits decoded by the memory; upper address bits pass through unchanged.
- STARVE_LIMIT, 4, consecutive denied I-request cycles before I is forced to win (range 1..15).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  one clock; reset is synchronous and active-high.
- i_req  in  1  fetch request; must be held with stable i_add until i_gnt.
- i_add  in  32  fetch byte address.
- i_gnt  out  1  fetch request accepted this cycle (combinational).
- i_rvalid  out  1  i_rdata valid; asserted exactly one cycle after i_gnt.
- i_rdata  out  32  fetch read data.
- d_req  in  1  load/store request; d_add, d_wen, d_wdata held stable until d_gnt.
- d_add  in  32  data byte address.
- d_wen  in  4  byte write enables; 4'b0000 means load.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_rvalid  out  1  response one cycle after d_gnt; for stores it is a write acknowledge.
- d_rdata  out  32  load data; for stores, pre-write word contents.
- m_add  out  32  memory address.
- m_wen  out  4  memory byte enables.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory registered read data, valid one cycle after the address.

## Operation
- Priority FSM, 2 states: PRIO_D (reset) and PRIO_I.
  - PRIO_D: d_req wins over i_req. If i_req is high and i_gnt is low, starve_cnt increments. When starve_cnt reaches STARVE_LIMIT, the next state is PRIO_I.
  - PRIO_I: i_req wins over d_req. Return to PRIO_D on the cycle after i_gnt. If i_req drops without a grant, return to PRIO_D.
  - starve_cnt clears on any i_gnt or when i_req is low. Width is 4 bits and saturates at STARVE_LIMIT.
- Grant is issued in the same cycle as the request; at most one of i_gnt/d_gnt is high per cycle.
- Memory mux:
  - Winner's address drives m_add.
  - m_wen = d_wen only when d_gnt; otherwise 4'b0000.
  - m_wdata = d_wdata when d_gnt; otherwise 0.
  - With no grant, m_add holds the last granted address.
- Response owner register resp_sel ∈ {NONE, I, D} captures the winner each cycle.
  - Next cycle, the owner's rvalid is 1 and its rdata = m_rdata.
  - Non-owner rdata is 0.
- Back-to-back grants every cycle are allowed (fully pipelined, throughput 1 access/cycle).
- Upper address bits are ignored by the memory; no range or alignment checking.

## Timing
- Reset values:
  - i_gnt, d_gnt, i_rvalid, d_rvalid = 0.
  - m_wen = 0, m_wdata = 0, m_add = 0.
  - resp_sel = NONE, state PRIO_D, starve_cnt 0.
  - i_rdata, d_rdata = 0.
- While reset is high, no grants are issued and m_wen is forced to 0.
- Reset mid-operation: a grant in the cycle before reset asserts produces no rvalid. The response is dropped; requesters must reissue.
- Latency: req→gnt is 0 cycles when the port wins; gnt→rvalid is 1 cycle.
- Simultaneous i_req and d_req:
  - In PRIO_D, D is granted and starve_cnt increments.
  - In PRIO_I, I is granted and D waits one cycle.
- Store followed by load to the same word on consecutive cycles returns the new data, because the memory write commits at the edge ending the store cycle.

## Structure
- Package mem_arb_pkg holds:
  - enum prio_state_t {PRIO_D, PRIO_I};
  - enum resp_owner_t {OWN_NONE, OWN_I, OWN_D};
  - constant STARVE_CNT_W = 4.
- One sub-module, mem_arb_starve_ctr: saturating counter plus limit compare, outputs force_i.
- All other logic stays in the top module.

## Test plan
- Single fetch: i_req with i_add=0x10, memory word 4 = 0xDEADBEEF → i_gnt same cycle; i_rvalid=1 and i_rdata=0xDEADBEEF next cycle; d_rvalid=0.
- Byte store then load: d_wen=4'b0010, d_add=0x20, d_wdata=0x0000AB00 over old word 0x11223344, followed by a load of 0x20 → store ack d_rvalid; load returns 0x1122AB44.
- Contention, STARVE_LIMIT=4: d_req and i_req held high continuously → D granted for 4 cycles; I granted in cycle 5; D again in cycle 6.
- Pipelined alternation: I, D, I grants on consecutive cycles → rvalid pulses on the respective ports in the next three cycles, with correct data routing and no cross-talk.
- Reset mid-operation: d_gnt store in cycle n, reset high in cycle n+1 → d_rvalid=0, state PRIO_D, counter 0, m_wen=0 during reset.
- Idle: no requests for 10 cycles → no grants, m_wen=0, rvalid low, starve_cnt stays 0.
